// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: Mealy stall/flush/freeze control for a 4-latch pipeline.
// Optional PIPE_PERF_EN adds saturating stall_cnt / flush_cnt performance counters.
module pipeline_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dmem_req,
  input  logic        branch_taken,
  input  logic        load_use,
  input  logic        halt_wb,
  output logic        pc_en,
  output logic        ifid_freeze,
  output logic        ifid_flush,
  output logic        idex_freeze,
  output logic        idex_flush,
  output logic        exmem_freeze,
  output logic        exmem_flush,
  output logic        memwb_freeze,
  output logic        memwb_flush,
  output logic        halted,
  output logic [1:0]  state
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt;
  state_t cur;
  logic   dstall;
  logic   flush_evt;

  // Outputs follow RUN rules while reset is held, regardless of the stored state.
  assign cur   = RST ? RUN : state_r;
  assign state = state_r;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt;
    end
  end

  always_comb begin
    pc_en        = 1'b0;
    ifid_freeze  = 1'b0;
    ifid_flush   = 1'b0;
    idex_freeze  = 1'b0;
    idex_flush   = 1'b0;
    exmem_freeze = 1'b0;
    exmem_flush  = 1'b0;
    memwb_freeze = 1'b0;
    memwb_flush  = 1'b0;
    halted       = 1'b0;
    flush_evt    = 1'b0;
    dstall       = 1'b0;
    state_nxt    = cur;

    if (cur == HALTED) begin
      ifid_freeze  = 1'b1;
      idex_freeze  = 1'b1;
      exmem_freeze = 1'b1;
      memwb_freeze = 1'b1;
      halted       = 1'b1;
    end else begin
      pc_en  = 1'b1;
      // Once waiting on data, only dhit releases the stall.
      dstall = (cur == DWAIT) ? !dhit : (dmem_req && !dhit);
      if (dstall) begin
        pc_en        = 1'b0;
        ifid_freeze  = 1'b1;
        idex_freeze  = 1'b1;
        exmem_freeze = 1'b1;
        memwb_flush  = 1'b1;
        state_nxt    = DWAIT;
      end else begin
        state_nxt = RUN;
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          flush_evt   = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          ifid_freeze = 1'b1;
          idex_flush  = 1'b1;
        end else if (!ihit) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end
      if (halt_wb) begin
        state_nxt = HALTED;
      end
    end
  end

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (!pc_en && cur != HALTED && stall_cnt_r != 32'hFFFF_FFFF) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (flush_evt && flush_cnt_r != 32'hFFFF_FFFF) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end
    end
  end
`else
  logic unused_flush_evt;
  assign unused_flush_evt = flush_evt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; inputs change #1 after posedge, outputs sampled at negedge.
module tb_pipeline_ctrl;
  logic CLK = 1'b0;
  logic RST, ihit, dhit, dmem_req, branch_taken, load_use, halt_wb;
  logic pc_en, ifid_freeze, ifid_flush, idex_freeze, idex_flush;
  logic exmem_freeze, exmem_flush, memwb_freeze, memwb_flush, halted;
  logic [1:0] state;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  int checks = 0;
  int failures = 0;

  // {pc_en, ifid_frz, ifid_fl, idex_frz, idex_fl, exmem_frz, exmem_fl, memwb_frz, memwb_fl, halted}
  localparam logic [9:0] ADV   = 10'b1000000000;
  localparam logic [9:0] STALL = 10'b0101010010;
  localparam logic [9:0] BR    = 10'b1010101000;
  localparam logic [9:0] LU    = 10'b0100100000;
  localparam logic [9:0] IMISS = 10'b0010000000;
  localparam logic [9:0] HALT  = 10'b0101010101;

  always #5 CLK = ~CLK;

  pipeline_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .branch_taken(branch_taken), .load_use(load_use), .halt_wb(halt_wb),
    .pc_en(pc_en), .ifid_freeze(ifid_freeze), .ifid_flush(ifid_flush),
    .idex_freeze(idex_freeze), .idex_flush(idex_flush),
    .exmem_freeze(exmem_freeze), .exmem_flush(exmem_flush),
    .memwb_freeze(memwb_freeze), .memwb_flush(memwb_flush),
    .halted(halted), .state(state)
`ifdef PIPE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  function automatic logic [9:0] ctl();
    return {pc_en, ifid_freeze, ifid_flush, idex_freeze, idex_flush,
            exmem_freeze, exmem_flush, memwb_freeze, memwb_flush, halted};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock, apply inputs, then settle to the negedge for sampling.
  task automatic cyc(input logic rst, input logic i, input logic d, input logic dm,
                     input logic b, input logic l, input logic h);
    @(posedge CLK);
    #1;
    RST = rst; ihit = i; dhit = d; dmem_req = dm; branch_taken = b; load_use = l; halt_wb = h;
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b1; dhit = 1'b0; dmem_req = 1'b0;
    branch_taken = 1'b0; load_use = 1'b0; halt_wb = 1'b0;
    @(negedge CLK);
    chk("rst_ctl", 32'(ctl()), 32'(ADV));
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_ctl", 32'(ctl()), 32'(ADV));

    // Data miss for three cycles, then hit.
    cyc(0, 1, 0, 1, 0, 0, 0);
    chk("dmiss1_state", 32'(state), 32'd0);
    chk("dmiss1_ctl", 32'(ctl()), 32'(STALL));
    cyc(0, 1, 0, 1, 0, 0, 0);
    chk("dmiss2_state", 32'(state), 32'd1);
    chk("dmiss2_ctl", 32'(ctl()), 32'(STALL));
    cyc(0, 1, 0, 1, 0, 0, 0);
    chk("dmiss3_ctl", 32'(ctl()), 32'(STALL));
    cyc(0, 1, 1, 1, 0, 0, 0);
    chk("dhit_state", 32'(state), 32'd1);
    chk("dhit_ctl", 32'(ctl()), 32'(ADV));
    cyc(0, 1, 1, 1, 0, 0, 0);
    chk("dhit_run_state", 32'(state), 32'd0);
    chk("dhit_run_ctl", 32'(ctl()), 32'(ADV));

    cyc(0, 1, 0, 0, 1, 1, 0);
    chk("br_lu_ctl", 32'(ctl()), 32'(BR));
    cyc(0, 1, 0, 1, 1, 0, 0);
    chk("br_dmiss_ctl", 32'(ctl()), 32'(STALL));
    // Now in DWAIT: dhit with branch resolves to branch rules and returns to RUN.
    cyc(0, 1, 1, 1, 1, 0, 0);
    chk("dwait_br_state", 32'(state), 32'd1);
    chk("dwait_br_ctl", 32'(ctl()), 32'(BR));
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("lu_imiss_state", 32'(state), 32'd0);
    chk("lu_imiss_ctl", 32'(ctl()), 32'(LU));
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("imiss_ctl", 32'(ctl()), 32'(IMISS));

    // Reset mid-DWAIT: outputs follow RUN rules, state forced to RUN.
    cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("rst_dwait_state", 32'(state), 32'd1);
    chk("rst_dwait_ctl", 32'(ctl()), 32'(ADV));
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("rst_dwait_after", 32'(state), 32'd0);

    // Halt pulsed inside DWAIT.
    cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 1);
    chk("halt_pulse_state", 32'(state), 32'd1);
    chk("halt_pulse_ctl", 32'(ctl()), 32'(STALL));
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("halted_state", 32'(state), 32'd2);
    chk("halted_ctl", 32'(ctl()), 32'(HALT));
    cyc(0, 1, 1, 0, 1, 0, 0);
    chk("halted_stay", 32'(state), 32'd2);
    chk("halted_stay_ctl", 32'(ctl()), 32'(HALT));
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("rst_halted_ctl", 32'(ctl()), 32'(ADV));
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("rst_halted_state", 32'(state), 32'd0);

`ifdef PIPE_PERF_EN
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("perf_rst_stall", stall_cnt, 32'd0);
    chk("perf_rst_flush", flush_cnt, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 1, 0);
    chk("perf_stall2", stall_cnt, 32'd2);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("perf_flush1", flush_cnt, 32'd1);
    chk("perf_stall_keep", stall_cnt, 32'd2);
    @(posedge CLK);
    #1;
    ihit = 1'b0;
    force dut.stall_cnt_r = 32'hFFFF_FFFE;
    @(negedge CLK);
    release dut.stall_cnt_r;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("perf_stall_sat", stall_cnt, 32'hFFFF_FFFF);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
